// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner: BCD decode, leading-zero blanking,
// frame-synchronous input shadowing and a dead cycle at every digit switch.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [DW-1:0]                div_cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   sh_bcd;
  logic [NUM_DIGITS-1:0]        sh_dp;
  logic                         sh_lz;
  logic                         tick;
  logic                         wrap;
  logic                         zero_run;
  logic [NUM_DIGITS-1:0]        lz_mask;
  logic [6:0]                   seg_next;
  logic                         dp_next;
  logic [NUM_DIGITS-1:0]        an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign tick = en && (div_cnt == DIV_LAST);
  assign wrap = (idx == IDX_LAST);

  // Scan from the most significant digit down; the run of blankable digits
  // ends at the first non-zero nibble or set decimal point. Digit 0 never blanks.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      zero_run = zero_run && (sh_bcd[NUM_DIGITS-i] == 4'd0) && !sh_dp[NUM_DIGITS-i];
      lz_mask[NUM_DIGITS-i] = sh_lz && zero_run;
    end
  end

  always_comb begin
    seg_next = '0;
    dp_next  = 1'b0;
    an_next  = '0;
    if (en && !lz_mask[idx]) begin
      seg_next = decode(sh_bcd[idx]);
      dp_next  = sh_dp[idx];
    end
    if (en && (div_cnt != '0)) begin
      an_next = NUM_DIGITS'(1) << idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      sh_bcd  <= '0;
      sh_dp   <= '0;
      sh_lz   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= wrap ? '0 : idx + 1'b1;
      if (wrap) begin
        sh_bcd <= bcd;
        sh_dp  <= dp_in;
        sh_lz  <= lz_blank;
      end
    end else if (en) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= {7{SEG_INV}};
      dp    <= SEG_INV;
      an    <= {NUM_DIGITS{AN_INV}};
      frame <= 1'b0;
    end else begin
      seg   <= seg_next ^ {7{SEG_INV}};
      dp    <= dp_next ^ SEG_INV;
      an    <= an_next ^ {NUM_DIGITS{AN_INV}};
      frame <= tick && wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle scoreboard against a behavioural model on two
// polarity variants, a table of decode/blanking vectors, and multi-cycle corner sequences.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [15:0]  bcd;
  logic [3:0]   dp_in;
  logic         lz_blank;
  logic [6:0]   seg, seg2;
  logic         dp, dp2;
  logic [3:0]   an, an2;
  logic         frame, frame2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp_in(dp_in), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .an(an), .frame(frame));

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) dut_pol (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp_in(dp_in), .lz_blank(lz_blank),
    .seg(seg2), .dp(dp2), .an(an2), .frame(frame2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  // Behavioural model, scoreboarded: expectation pushed per edge, popped on negedge.
  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;
  } exp_t;
  exp_t q[$];

  int          m_div, m_idx;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_lz;

  function automatic logic blankd(input int k);
    if (!m_lz || k == 0) return 1'b0;
    for (int j = k; j < N; j++)
      if (m_bcd[4*j +: 4] != 4'd0 || m_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    exp_t e;
    if (rst) begin
      m_div = 0; m_idx = 0; m_bcd = '0; m_dp = '0; m_lz = 1'b0;
      q.delete();
      e = '{7'h00, 1'b0, 4'hF, 1'b0};
      q.push_back(e);
    end else begin
      e.frame = en && (m_div == SD-1) && (m_idx == N-1);
      e.an    = (en && m_div != 0) ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg   = (en && !blankd(m_idx)) ? dec(m_bcd[4*m_idx +: 4]) : 7'h00;
      e.dp    = en && !blankd(m_idx) && m_dp[m_idx];
      if (en) begin
        if (m_div == SD-1) begin
          m_div = 0;
          if (m_idx == N-1) begin
            m_idx = 0; m_bcd = bcd; m_dp = dp_in; m_lz = lz_blank;
          end else m_idx++;
        end else m_div++;
      end
      q.push_back(e);
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("cyc", {19'd0, seg, dp, an, frame}, {19'd0, e.seg, e.dp, e.an, e.frame});
      check("cyc_pol", {19'd0, seg2, dp2, an2, frame2}, {19'd0, ~e.seg, ~e.dp, ~e.an, e.frame});
    end
  end

  task automatic wait_frame();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame) return;
    end
    timeout("wait_frame");
  endtask

  task automatic wait_digit(input int d);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an == want) return;
    end
    timeout($sformatf("wait_digit%0d", d));
  endtask

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpi;
    logic        lz;
    int          dig;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t vecs[19];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    vecs[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 7'h66, 1'b0};
    vecs[1]  = '{16'h1234, 4'b0000, 1'b0, 1, 7'h4F, 1'b0};
    vecs[2]  = '{16'h1234, 4'b0000, 1'b0, 2, 7'h5B, 1'b0};
    vecs[3]  = '{16'h1234, 4'b0000, 1'b0, 3, 7'h06, 1'b0};
    vecs[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 7'h00, 1'b0};
    vecs[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 7'h00, 1'b0};
    vecs[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 7'h6D, 1'b0};
    vecs[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};
    vecs[8]  = '{16'h0050, 4'b0000, 1'b0, 3, 7'h3F, 1'b0};
    vecs[9]  = '{16'h0007, 4'b0100, 1'b1, 3, 7'h00, 1'b0};
    vecs[10] = '{16'h0007, 4'b0100, 1'b1, 2, 7'h3F, 1'b1};
    vecs[11] = '{16'h0007, 4'b0100, 1'b1, 1, 7'h3F, 1'b0};
    vecs[12] = '{16'h0007, 4'b0100, 1'b1, 0, 7'h07, 1'b0};
    vecs[13] = '{16'h12C4, 4'b0000, 1'b0, 1, 7'h00, 1'b0};
    vecs[14] = '{16'hF358, 4'b0000, 1'b0, 0, 7'h7F, 1'b0};
    vecs[15] = '{16'h0000, 4'b0001, 1'b1, 0, 7'h3F, 1'b1};
    vecs[16] = '{16'h0000, 4'b0001, 1'b1, 1, 7'h00, 1'b0};
    vecs[17] = '{16'h9876, 4'b0000, 1'b1, 3, 7'h6F, 1'b0};
    vecs[18] = '{16'h00A0, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};

    rst = 1'b1; en = 1'b0; bcd = '0; dp_in = '0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h00);
    check("rst_frame", {31'd0, frame}, 32'h0);
    check("rst_seg_pol", {25'd0, seg2}, 32'h7F);
    check("rst_an_pol", {28'd0, an2}, 32'h0);
    rst = 1'b0;
    en  = 1'b1;

    // Table: new inputs reach the display only after the next frame capture
    foreach (vecs[i]) begin
      @(negedge clk);
      bcd = vecs[i].bcd; dp_in = vecs[i].dpi; lz_blank = vecs[i].lz;
      wait_frame();
      wait_digit(vecs[i].dig);
      check($sformatf("vec%0d_seg", i), {25'd0, seg}, {25'd0, vecs[i].seg});
      check($sformatf("vec%0d_dp", i), {31'd0, dp}, {31'd0, vecs[i].dp});
    end

    // Frame period and mid-frame input change
    @(negedge clk);
    bcd = 16'h1234; dp_in = '0; lz_blank = 1'b0;
    wait_frame();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cnt++;
      if (frame) break;
    end
    check("frame_period", cnt, 16);
    wait_digit(1);
    bcd = 16'h9876;
    wait_digit(2);
    check("tear_d2", {25'd0, seg}, 32'h5B);
    wait_digit(3);
    check("tear_d3", {25'd0, seg}, 32'h06);
    wait_digit(0);
    check("new_d0", {25'd0, seg}, 32'h7D);

    // Pause mid-digit: all off, then resume on the same digit
    wait_digit(2);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("pause_an", {28'd0, an}, 32'hF);
    check("pause_seg", {25'd0, seg}, 32'h00);
    en = 1'b1;
    @(negedge clk);
    check("resume_an", {28'd0, an}, 32'hB);

    // Asynchronous reset mid-frame, restart at digit 0
    wait_digit(1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {25'd0, seg}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an != 4'hF) break;
      cnt++;
    end
    check("restart_digit", {28'd0, an}, 32'hE);
    check("restart_delay", cnt, 1);

    // Inverted-polarity variant showing an 8 on digit 0
    @(negedge clk);
    bcd = 16'h0008; dp_in = '0; lz_blank = 1'b0;
    wait_frame();
    wait_frame();
    wait_digit(0);
    check("pol_seg", {25'd0, seg2}, 32'h00);
    check("pol_an", {28'd0, an2}, 32'h1);
    check("pol_seg_norm", {25'd0, seg}, 32'h7F);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
